// File: rtl/cmd_mem_engine.sv
// cmd_mem_engine: byte-stream command processor with a local MEM_DEPTH x 8 RAM.
// The host pushes 4-byte headers (LSB first) and payload into an input FIFO. The engine
// executes RESET / READ / WRITE / FILL and returns read data through an output FIFO.
// Optional feature macro: CMD_MEM_ENGINE_CHECKSUM_EN appends an XOR checksum byte to
// every READ response.
// Handshake: a byte moves into or out of a FIFO on a rising clock edge where the request
// (i_in_valid / i_out_read) is high and the FIFO can take or give it. A full input FIFO
// still accepts a push in a cycle where the engine pops. A pop on an empty output FIFO
// is ignored.
module cmd_mem_engine #(
    parameter int ADDR_BITS  = 14,
    parameter int LEN_BITS   = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_full,
    input  logic       i_out_read,
    output logic [7:0] o_out_data,
    output logic       o_out_empty,
    output logic       o_busy,
    output logic       o_dev_rst,
    output logic [7:0] o_err_count
);
    localparam int MEM_DEPTH = 2 ** ADDR_BITS;
    localparam int CW        = $clog2(FIFO_DEPTH);
    localparam int RCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW:0]       DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam logic [LEN_BITS:0] ONE_L   = (LEN_BITS + 1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_DISPATCH, S_RST, S_READ, S_WRITE, S_FILL_PAT, S_FILL, S_CSUM
    } state_t;

    state_t               state;
    logic [31:0]          hdr;
    logic [1:0]           hdr_cnt;
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS:0]    left;
    logic                 rd_pend;
    logic [7:0]           ram_q;
    logic [7:0]           pattern;
    logic [RCW-1:0]       rst_cnt;
`ifdef CMD_MEM_ENGINE_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    logic [7:0] ram [MEM_DEPTH];

    // Input FIFO
    logic [7:0] in_mem [FIFO_DEPTH];
    logic [CW:0] in_wp, in_rp, in_lvl;
    logic        in_empty, in_pop, in_push;
    logic [7:0]  in_head;

    // Output FIFO
    logic [7:0] out_mem [FIFO_DEPTH];
    logic [CW:0] out_wp, out_rp, out_lvl;
    logic        out_full, out_pop, out_push, out_acc;
    logic [7:0]  out_wdata;

    logic        rd_issue, ram_we;
    logic [7:0]  ram_wdata;
    logic [CW+1:0] occ;

    assign in_lvl    = in_wp - in_rp;
    assign in_empty  = (in_lvl == '0);
    assign o_in_full = (in_lvl == DEPTH_L);
    assign in_head   = in_mem[in_rp[CW-1:0]];
    assign in_push   = i_in_valid && (!o_in_full || in_pop);

    assign out_lvl     = out_wp - out_rp;
    assign o_out_empty = (out_lvl == '0);
    assign out_full    = (out_lvl == DEPTH_L);
    assign out_pop     = i_out_read && !o_out_empty;
    assign out_acc     = out_push && (!out_full || out_pop);
    assign o_out_data  = o_out_empty ? 8'h00 : out_mem[out_rp[CW-1:0]];

    assign o_busy = !(state == S_IDLE || state == S_HDR);

    // Engine-side strobes are decoded from the registered state.
    assign in_pop = !in_empty && (state == S_IDLE || state == S_HDR ||
                                  state == S_WRITE || state == S_FILL_PAT);
    // Issue a RAM read only if the byte still in flight and this one both fit.
    assign occ      = {1'b0, out_lvl} + (CW + 2)'(rd_pend);
    assign rd_issue = (state == S_READ) && (left != '0) && (occ < (CW + 2)'(FIFO_DEPTH));
    assign ram_we    = (state == S_WRITE && !in_empty) || (state == S_FILL);
    assign ram_wdata = (state == S_FILL) ? pattern : in_head;
`ifdef CMD_MEM_ENGINE_CHECKSUM_EN
    assign out_push  = (state == S_READ && rd_pend) || (state == S_CSUM && !out_full);
    assign out_wdata = (state == S_CSUM) ? csum : ram_q;
`else
    assign out_push  = (state == S_READ) && rd_pend;
    assign out_wdata = ram_q;
`endif

    // FIFO pointers, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_wp  <= '0;
            in_rp  <= '0;
            out_wp <= '0;
            out_rp <= '0;
        end else begin
            if (in_push)  in_wp  <= in_wp + 1'b1;
            if (in_pop)   in_rp  <= in_rp + 1'b1;
            if (out_acc)  out_wp <= out_wp + 1'b1;
            if (out_pop)  out_rp <= out_rp + 1'b1;
        end
    end

    // FIFO storage and RAM: data only, never reset.
    always_ff @(posedge i_clk) begin
        if (in_push)  in_mem[in_wp[CW-1:0]]   <= i_in_data;
        if (out_acc)  out_mem[out_wp[CW-1:0]] <= out_wdata;
        if (ram_we)   ram[addr] <= ram_wdata;
        if (rd_issue) ram_q <= ram[addr];
    end

    // Command FSM: header assembly, dispatch and per-op sequencing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            hdr         <= '0;
            hdr_cnt     <= '0;
            addr        <= '0;
            left        <= '0;
            rd_pend     <= 1'b0;
            pattern     <= '0;
            rst_cnt     <= '0;
            o_dev_rst   <= 1'b0;
            o_err_count <= '0;
`ifdef CMD_MEM_ENGINE_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (!in_empty) begin
                    hdr     <= {in_head, hdr[31:8]};
                    hdr_cnt <= 2'd1;
                    state   <= S_HDR;
                end
                S_HDR: if (!in_empty) begin
                    hdr     <= {in_head, hdr[31:8]};
                    hdr_cnt <= hdr_cnt + 1'b1;
                    if (hdr_cnt == 2'd3) state <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    addr    <= hdr[14 +: ADDR_BITS];
                    left    <= {1'b0, hdr[LEN_BITS-1:0]} + ONE_L;
                    rd_pend <= 1'b0;
`ifdef CMD_MEM_ENGINE_CHECKSUM_EN
                    csum    <= '0;
`endif
                    case (hdr[31:28])
                        4'd0: begin
                            o_dev_rst <= 1'b1;
                            rst_cnt   <= RCW'(RST_CYCLES - 1);
                            state     <= S_RST;
                        end
                        4'd1: state <= S_READ;
                        4'd2: state <= S_WRITE;
                        4'd3: state <= S_FILL_PAT;
                        default: begin
                            if (o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
                            state <= S_IDLE;
                        end
                    endcase
                end
                S_RST: begin
                    if (rst_cnt == '0) begin
                        o_dev_rst <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_READ: begin
                    rd_pend <= rd_issue;
                    if (rd_issue) begin
                        addr <= addr + 1'b1;
                        left <= left - 1'b1;
                    end
`ifdef CMD_MEM_ENGINE_CHECKSUM_EN
                    if (rd_pend) csum <= csum ^ ram_q;
                    if (rd_pend && left == '0) state <= S_CSUM;
`else
                    if (rd_pend && left == '0) state <= S_IDLE;
`endif
                end
                S_CSUM: if (!out_full) state <= S_IDLE;
                S_WRITE: if (!in_empty) begin
                    addr <= addr + 1'b1;
                    left <= left - 1'b1;
                    if (left == ONE_L) state <= S_IDLE;
                end
                S_FILL_PAT: if (!in_empty) begin
                    pattern <= in_head;
                    state   <= S_FILL;
                end
                S_FILL: begin
                    addr <= addr + 1'b1;
                    left <= left - 1'b1;
                    if (left == ONE_L) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
